// File: rtl/iopage_master.sv
// CPU-side initiator for the I/O-page bus: detects top-8KB accesses, sequences
// decode/strobe/completion with the register slaves, and returns ack, data or NXM.
module iopage_master #(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic        cpu_byte_op,
    input  logic [21:0] cpu_addr,
    input  logic [15:0] cpu_data_in,
    output logic [15:0] cpu_data_out,
    output logic        cpu_ack,
    output logic        cpu_nxm,
    output logic        busy,
    output logic [12:0] iopage_addr,
    output logic [15:0] iopage_data_out,
    output logic        iopage_rd,
    output logic        iopage_wr,
    output logic        iopage_byte_op,
    input  logic        iopage_decode,
    input  logic [15:0] iopage_data_in
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ACCESS,
        S_DONE,
        S_NXM
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          wr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            count           <= '0;
            wr_q            <= 1'b0;
            cpu_data_out    <= '0;
            cpu_ack         <= 1'b0;
            cpu_nxm         <= 1'b0;
            busy            <= 1'b0;
            iopage_addr     <= '0;
            iopage_data_out <= '0;
            iopage_rd       <= 1'b0;
            iopage_wr       <= 1'b0;
            iopage_byte_op  <= 1'b0;
        end else begin
            cpu_ack   <= 1'b0;
            cpu_nxm   <= 1'b0;
            iopage_rd <= 1'b0;
            iopage_wr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_req && cpu_addr[21:13] == 9'o777) begin
                        iopage_addr     <= cpu_addr[12:0];
                        iopage_data_out <= cpu_data_in;
                        iopage_byte_op  <= cpu_byte_op;
                        wr_q            <= cpu_wr;
                        count           <= '0;
                        busy            <= 1'b1;
                        state           <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (iopage_decode) begin
                        iopage_rd <= ~wr_q;
                        iopage_wr <= wr_q;
                        state     <= S_ACCESS;
                    end else if (count == LAST) begin
                        cpu_ack <= 1'b1;
                        cpu_nxm <= 1'b1;
                        state   <= S_NXM;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_ACCESS: begin
                    // Read data is captured at the close of the strobe cycle,
                    // so decode dropping here cannot abort the access.
                    if (!wr_q) begin
                        if (iopage_byte_op && iopage_addr[0])
                            cpu_data_out <= {8'h00, iopage_data_in[15:8]};
                        else if (iopage_byte_op)
                            cpu_data_out <= {8'h00, iopage_data_in[7:0]};
                        else
                            cpu_data_out <= iopage_data_in;
                    end
                    cpu_ack <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE, S_NXM: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iopage_master.sv
// Randomized self-checking bench for iopage_master against a transaction-level
// model of ack latency, strobes, NXM and returned data.
module tb_iopage_master;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_wr;
    logic        cpu_byte_op;
    logic [21:0] cpu_addr;
    logic [15:0] cpu_data_in;
    logic [15:0] cpu_data_out;
    logic        cpu_ack;
    logic        cpu_nxm;
    logic        busy;
    logic [12:0] iopage_addr;
    logic [15:0] iopage_data_out;
    logic        iopage_rd;
    logic        iopage_wr;
    logic        iopage_byte_op;
    logic        iopage_decode;
    logic [15:0] iopage_data_in;

    logic        slave_en;
    logic [12:0] slave_addr;
    logic [15:0] slave_data;

    int unsigned check_count = 0;
    int unsigned err_count = 0;
    logic [15:0] exp_dout = '0;

    always #5 clk = ~clk;

    // Word-decoding stub slave
    assign iopage_decode  = slave_en && (iopage_addr[12:1] == slave_addr[12:1]);
    assign iopage_data_in = iopage_decode ? slave_data : 16'h0000;

    iopage_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
        .cpu_byte_op(cpu_byte_op), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
        .cpu_data_out(cpu_data_out), .cpu_ack(cpu_ack), .cpu_nxm(cpu_nxm), .busy(busy),
        .iopage_addr(iopage_addr), .iopage_data_out(iopage_data_out),
        .iopage_rd(iopage_rd), .iopage_wr(iopage_wr), .iopage_byte_op(iopage_byte_op),
        .iopage_decode(iopage_decode), .iopage_data_in(iopage_data_in)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs !== exp) begin
            err_count++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] read_value(input logic bo, input logic a0, input logic [15:0] d);
        if (!bo) return d;
        return a0 ? {8'h00, d[15:8]} : {8'h00, d[7:0]};
    endfunction

    // One access with a one-cycle request; observes 13 edges and compares
    // against the transaction-level expectation.
    task automatic run_access(input string tag, input logic [21:0] a, input logic wr,
                              input logic bo, input logic [15:0] wd);
        int ack_edge = -1;
        int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, ack_cnt = 0, busy_cnt = 0;
        logic nxm_seen = 1'b0;
        logic [15:0] dout_seen = '0, wdata_seen = '0;
        logic in_page, hit;
        int exp_edge;

        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = a; cpu_wr = wr; cpu_byte_op = bo; cpu_data_in = wd;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (iopage_rd) rd_cnt++;
            if (iopage_wr) begin wr_cnt++; wdata_seen = iopage_data_out; end
            if (iopage_rd && iopage_wr) both_cnt++;
            if (busy) busy_cnt++;
            if (cpu_ack) begin
                ack_cnt++;
                if (ack_edge < 0) begin
                    ack_edge = k + 1; nxm_seen = cpu_nxm; dout_seen = cpu_data_out;
                end
            end
        end

        in_page  = (a[21:13] == 9'o777);
        hit      = in_page && slave_en && (a[12:1] == slave_addr[12:1]);
        exp_edge = !in_page ? -1 : (hit ? 3 : int'(TO) + 1);
        if (hit && !wr) exp_dout = read_value(bo, a[0], slave_data);

        check({tag, "_ack_edge"}, 64'(ack_edge), 64'(exp_edge));
        check({tag, "_ack_cnt"}, 64'(ack_cnt), in_page ? 64'd1 : 64'd0);
        check({tag, "_nxm"}, 64'(nxm_seen), (in_page && !hit) ? 64'd1 : 64'd0);
        check({tag, "_rd_cnt"}, 64'(rd_cnt), (hit && !wr) ? 64'd1 : 64'd0);
        check({tag, "_wr_cnt"}, 64'(wr_cnt), (hit && wr) ? 64'd1 : 64'd0);
        check({tag, "_both"}, 64'(both_cnt), 64'd0);
        check({tag, "_dout"}, 64'(cpu_data_out), 64'(exp_dout));
        if (in_page) begin
            check({tag, "_ack_data"}, 64'(dout_seen), 64'(exp_dout));
            check({tag, "_io_addr"}, 64'(iopage_addr), 64'(a[12:0]));
            check({tag, "_io_bo"}, 64'(iopage_byte_op), 64'(bo));
            check({tag, "_io_wdata"}, 64'(iopage_data_out), 64'(wd));
        end else begin
            check({tag, "_busy"}, 64'(busy_cnt), 64'd0);
        end
        if (hit && wr) check({tag, "_wdata_strobe"}, 64'(wdata_seen), 64'(wd));
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {cpu_data_out, cpu_ack, cpu_nxm, busy, iopage_addr, iopage_data_out,
                    iopage_rd, iopage_wr, iopage_byte_op}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_edges[$];
        reset = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_byte_op = 1'b0;
        cpu_addr = '0; cpu_data_in = '0;
        slave_en = 1'b1; slave_addr = 13'o17570; slave_data = 16'o123456;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_state");
        reset = 1'b0;

        run_access("t1_word_rd", 22'o17777570, 1'b0, 1'b0, 16'h0000);
        check("t1_value", 64'(cpu_data_out), 64'(16'o123456));
        slave_data = 16'hA55A;
        run_access("t2_odd_byte", 22'o17777571, 1'b0, 1'b1, 16'h0000);
        check("t2_odd_value", 64'(cpu_data_out), 64'h00A5);
        run_access("t2_even_byte", 22'o17777570, 1'b0, 1'b1, 16'h0000);
        check("t2_even_value", 64'(cpu_data_out), 64'h005A);
        run_access("t3_write", 22'o17777570, 1'b1, 1'b0, 16'o000777);
        run_access("t4_nxm", 22'o17777000, 1'b0, 1'b0, 16'h0000);
        run_access("t5_outside", 22'o00001000, 1'b0, 1'b0, 16'h0000);

        // Reset during ACCESS (slave hit) and during DECODE (no slave)
        for (int r = 0; r < 2; r++) begin
            int ack_cnt = 0;
            @(negedge clk);
            cpu_req = 1'b1; cpu_addr = (r == 0) ? 22'o17777570 : 22'o17777000;
            cpu_wr = 1'b0; cpu_byte_op = 1'b0; cpu_data_in = 16'h1234;
            @(posedge clk); #1 cpu_req = 1'b0;
            if (r == 0) begin @(posedge clk); #1; end
            check(r == 0 ? "t5_in_access_rd" : "t5_in_decode_busy",
                  r == 0 ? 64'(iopage_rd) : 64'(busy), 64'd1);
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            exp_dout = '0;
            check_all_zero(r == 0 ? "t5_rst_access" : "t5_rst_decode");
            for (int k = 0; k < 8; k++) begin
                @(posedge clk); #1;
                if (cpu_ack || cpu_nxm || busy) ack_cnt++;
            end
            check(r == 0 ? "t5_quiet_access" : "t5_quiet_decode", 64'(ack_cnt), 64'd0);
        end

        // Back-to-back with req held high across the first ack
        slave_data = 16'h4321;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 22'o17777570; cpu_wr = 1'b0; cpu_byte_op = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= 12 && ack_edges.size() < 2; k++) begin
            @(posedge clk); #1;
            if (cpu_ack) ack_edges.push_back(k + 1);
            if (ack_edges.size() == 2) cpu_req = 1'b0;
        end
        cpu_req = 1'b0;
        check("t6_ack_count", 64'(ack_edges.size()), 64'd2);
        if (ack_edges.size() == 2) begin
            check("t6_first_ack", 64'(ack_edges[0]), 64'd3);
            check("t6_second_ack", 64'(ack_edges[1]), 64'd7);
        end
        exp_dout = 16'h4321;
        repeat (3) @(posedge clk);

        // Randomized mix of hits, in-page misses and out-of-page requests
        for (int n = 0; n < 60; n++) begin
            logic [21:0] a;
            logic [8:0]  top;
            int unsigned kind = $urandom_range(0, 2);
            slave_en   = ($urandom_range(0, 7) != 0);
            slave_addr = 13'($urandom);
            slave_data = 16'($urandom);
            a = {9'o777, slave_addr[12:1], 1'($urandom)};
            if (kind == 1) a[12:1] = slave_addr[12:1] ^ 12'($urandom_range(1, 4095));
            if (kind == 2) begin
                top = 9'($urandom);
                if (top == 9'o777) top = 9'o000;
                a[21:13] = top;
            end
            run_access("rand", a, 1'($urandom), 1'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", check_count, err_count);
        $finish;
    end

endmodule
